rx_word_checker: RTL

RX_WORD_CHECKER -- requirements
Module: rx_word_checker

---
 rtl/rx_word_checker.sv | 106 ++++++++++
 1 files changed

// File: rtl/rx_word_checker.sv
// Received-word sequence checker: locks onto an incrementing modulo-16 word stream and counts errors while locked.
// Optional io_sticky error flag is built when RX_WORD_CHECKER_STICKY_EN is defined.
module rx_word_checker #(
    parameter int unsigned LOCK_N = 3,
    parameter int unsigned LOSS_N = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_valid,
    input  logic [3:0]       io_input,
    input  logic             io_clear,
    output logic             io_locked,
    output logic [3:0]       io_expected,
    output logic [CNT_W-1:0] io_word_count,
    output logic [CNT_W-1:0] io_error_count,
    output logic             io_error
`ifdef RX_WORD_CHECKER_STICKY_EN
    ,
    output logic             io_sticky
`endif
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } rxState_e;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);
    localparam logic [3:0] LOSS_RUN = 4'(LOSS_N);

    rxState_e   state;
    logic [3:0] matchRun;
    logic [3:0] missRun;
    logic       isMatch;
    logic [3:0] matchNext;
    logic [3:0] missNext;

    always_comb begin
        isMatch   = (io_input == io_expected);
        matchNext = isMatch ? (matchRun + 4'd1) : 4'd1;
        missNext  = missRun + 4'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= SEARCH;
            matchRun       <= '0;
            missRun        <= '0;
            io_expected    <= '0;
            io_word_count  <= '0;
            io_error_count <= '0;
            io_error       <= 1'b0;
            io_locked      <= 1'b0;
`ifdef RX_WORD_CHECKER_STICKY_EN
            io_sticky      <= 1'b0;
`endif
        end else begin
            io_error <= 1'b0;
`ifdef RX_WORD_CHECKER_STICKY_EN
            // Cleared first so a mismatch in this same cycle sets it again.
            if (io_clear) io_sticky <= 1'b0;
`endif
            if (io_valid) begin
                case (state)
                    SEARCH: begin
                        io_expected <= io_input + 4'd1;
                        matchRun    <= matchNext;
                        if (matchNext == LOCK_RUN) begin
                            state     <= LOCKED;
                            missRun   <= '0;
                            io_locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: expected advances whether or not the word matched.
                        io_expected <= io_expected + 4'd1;
                        if (io_word_count != '1) io_word_count <= io_word_count + 1'b1;
                        if (isMatch) begin
                            missRun <= '0;
                        end else begin
                            if (io_error_count != '1) io_error_count <= io_error_count + 1'b1;
                            io_error <= 1'b1;
                            missRun  <= missNext;
`ifdef RX_WORD_CHECKER_STICKY_EN
                            io_sticky <= 1'b1;
`endif
                            if (missNext == LOSS_RUN) begin
                                state     <= SEARCH;
                                matchRun  <= '0;
                                missRun   <= '0;
                                io_locked <= 1'b0;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            if (io_clear) begin
                io_word_count  <= '0;
                io_error_count <= '0;
            end
        end
    end

endmodule
